// File: rtl/level_pkg.sv
// Shared types and helpers for the liquid-level datapath.
// Latency: none (types and a combinational decode function only).
// Backpressure: none.
package level_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    HIGH   = 2'b01,
    LOW    = 2'b10,
    FAULT  = 2'b11
  } alarm_state_t;

  localparam int LEVEL_MAX = 8;

  // Thermometer decode: returns {valid, level}. A word is valid only when it
  // is 2^n-1, i.e. a contiguous run of ones from bit0 with no gaps.
  function automatic logic [4:0] therm_decode(input logic [7:0] word);
    logic [4:0] res;
    res = 5'b0_0000;
    for (int n = 0; n <= LEVEL_MAX; n++) begin
      if (word == 8'((9'd1 << n) - 9'd1)) res = {1'b1, 4'(n)};
    end
    return res;
  endfunction

endpackage

// File: rtl/sensor_sampler.sv
// Synchronises the sensor bus, samples it on a divided tick and filters it for stability.
// Latency: 2-cycle synchroniser; acc_vld registers the cycle after the STABLE_CNT-th equal tick.
// Backpressure: none; the accepted word is a single-cycle pulse the consumer must take.
module sensor_sampler
  import level_pkg::*;
#(
  parameter int SAMPLE_DIV = 100_000,
  parameter int STABLE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sensors_dat,
  output logic       acc_vld,
  output logic [7:0] acc_dat
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam int SW = $clog2(STABLE_CNT + 1);

  logic [7:0]    sync1, sync2, prev_word, last_word;
  logic [CW-1:0] tick_cnt;
  logic [SW-1:0] stable_cnt, stable_nxt;
  logic          first_done;
  logic          tick, same, accept;

  // Tick fires on the wrap of the free-running divider.
  assign tick = (tick_cnt == CW'(SAMPLE_DIV - 1));
  assign same = (sync2 == prev_word);

  // Saturating stability count; a new word restarts at 1. Accept only on the
  // cycle the count first reaches the target, and only for a changed word
  // (or the very first word after reset).
  always_comb begin
    stable_nxt = stable_cnt;
    if (same) begin
      if (stable_cnt != SW'(STABLE_CNT)) stable_nxt = stable_cnt + 1'b1;
    end else begin
      stable_nxt = SW'(1);
    end
    accept = tick && (stable_nxt == SW'(STABLE_CNT))
             && ((stable_cnt != SW'(STABLE_CNT)) || !same)
             && (!first_done || (sync2 != last_word));
  end

  // Synchroniser, divider, stability filter and accepted-word register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 8'h00;
      sync2      <= 8'h00;
      tick_cnt   <= '0;
      stable_cnt <= '0;
      prev_word  <= 8'h00;
      last_word  <= 8'h00;
      first_done <= 1'b0;
      acc_vld    <= 1'b0;
      acc_dat    <= 8'h00;
    end else begin
      sync1    <= sensors_dat;
      sync2    <= sync1;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      acc_vld  <= accept;
      if (tick) begin
        stable_cnt <= stable_nxt;
        prev_word  <= sync2;
      end
      if (accept) begin
        acc_dat    <= sync2;
        last_word  <= sync2;
        first_done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/level_alarm_controller.sv
// Level alarm sequencer: sampled level decode, threshold capture and the NORMAL/HIGH/LOW/FAULT FSM.
// Latency: outputs register the cycle after an accepted word or after a threshold change.
// Backpressure: none; button edges and accepted words are consumed in the cycle they occur.
module level_alarm_controller
  import level_pkg::*;
#(
  parameter int SAMPLE_DIV = 100_000,
  parameter int STABLE_CNT = 4,
  parameter int HYST       = 1
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic [7:0] sensors_input,
  input  logic [7:0] setup_input,
  input  logic       saveH_button,
  input  logic       saveL_button,
  output logic [3:0] level,
  output logic       level_valid,
  output logic [1:0] alarm_state,
  output logic [3:0] thr_high,
  output logic [3:0] thr_low,
  output logic       cfg_err,
  output logic       state_chg
);

  logic         acc_vld;
  logic [7:0]   acc_dat;
  logic         btn_h_q, btn_l_q, h_rise, l_rise, h_ok, l_ok, save_rej;
  logic         thr_chg;
  logic [4:0]   setup_dec, acc_dec;
  alarm_state_t state, state_nxt;
  logic [3:0]   level_nxt;
  logic         valid_nxt;

  sensor_sampler #(
    .SAMPLE_DIV (SAMPLE_DIV),
    .STABLE_CNT (STABLE_CNT)
  ) u_sampler (
    .clk         (clk_100MHz),
    .rst_n       (reset_n),
    .sensors_dat (sensors_input),
    .acc_vld     (acc_vld),
    .acc_dat     (acc_dat)
  );

  // Alarm rules in priority order; compares are 5 bits wide so lvl+HYST cannot wrap.
  function automatic alarm_state_t eval_alarm(input logic [3:0] lvl, input alarm_state_t prev,
                                              input logic [3:0] hi, input logic [3:0] lo);
    logic [4:0] l5, h5, o5, hy5;
    l5  = {1'b0, lvl};
    h5  = {1'b0, hi};
    o5  = {1'b0, lo};
    hy5 = 5'(HYST);
    if (l5 >= h5)                               return HIGH;
    else if (l5 <= o5)                          return LOW;
    else if (prev == HIGH && (l5 + hy5) >= h5)  return HIGH;
    else if (prev == LOW && l5 <= (o5 + hy5))   return LOW;
    else                                        return NORMAL;
  endfunction

  // Save validation: a lone rising edge with a valid setup code that keeps low < high.
  always_comb begin
    setup_dec = therm_decode(setup_input);
    h_rise    = saveH_button & ~btn_h_q;
    l_rise    = saveL_button & ~btn_l_q;
    h_ok      = h_rise & ~l_rise & setup_dec[4] & (setup_dec[3:0] > thr_low);
    l_ok      = l_rise & ~h_rise & setup_dec[4] & (setup_dec[3:0] < thr_high);
    save_rej  = (h_rise | l_rise) & ~(h_ok | l_ok);
  end

  // Next alarm state: an accepted word wins; otherwise a threshold change
  // re-evaluates the held level, except while in FAULT or before any valid level.
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    valid_nxt = level_valid;
    acc_dec   = therm_decode(acc_dat);
    if (acc_vld) begin
      if (!acc_dec[4]) begin
        state_nxt = FAULT;
        valid_nxt = 1'b0;
      end else begin
        level_nxt = acc_dec[3:0];
        valid_nxt = 1'b1;
        state_nxt = eval_alarm(acc_dec[3:0], state, thr_high, thr_low);
      end
    end else if (thr_chg && level_valid && state != FAULT) begin
      state_nxt = eval_alarm(level, state, thr_high, thr_low);
    end
  end

  // Button edge flops and threshold registers.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      btn_h_q  <= 1'b0;
      btn_l_q  <= 1'b0;
      thr_high <= 4'(LEVEL_MAX);
      thr_low  <= 4'd0;
      thr_chg  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      btn_h_q <= saveH_button;
      btn_l_q <= saveL_button;
      thr_chg <= h_ok | l_ok;
      cfg_err <= save_rej;
      if (h_ok) thr_high <= setup_dec[3:0];
      if (l_ok) thr_low  <= setup_dec[3:0];
    end
  end

  // Alarm state register with registered level and change pulse.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= NORMAL;
      level       <= 4'd0;
      level_valid <= 1'b0;
      state_chg   <= 1'b0;
    end else begin
      state       <= state_nxt;
      level       <= level_nxt;
      level_valid <= valid_nxt;
      state_chg   <= (state_nxt != state);
    end
  end

  assign alarm_state = state;

endmodule

// File: tb/tb_level_alarm_controller.sv
// Directed bench for level_alarm_controller with a fast sample tick.
// Latency: waits are fixed cycle budgets well beyond the 3-tick filter.
// Backpressure: none.
module tb_level_alarm_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] sensors_input, setup_input;
  logic       saveH_button, saveL_button;
  logic [3:0] level, thr_high, thr_low;
  logic       level_valid, cfg_err, state_chg;
  logic [1:0] alarm_state;

  int tests = 0;
  int fails = 0;
  int chg_cnt = 0;
  int err_cnt = 0;
  int chg0, err0;

  localparam logic [1:0] S_NORMAL = 2'b00, S_HIGH = 2'b01, S_LOW = 2'b10, S_FAULT = 2'b11;

  level_alarm_controller #(.SAMPLE_DIV(4), .STABLE_CNT(3), .HYST(1)) dut (
    .clk_100MHz    (clk),
    .reset_n       (reset_n),
    .sensors_input (sensors_input),
    .setup_input   (setup_input),
    .saveH_button  (saveH_button),
    .saveL_button  (saveL_button),
    .level         (level),
    .level_valid   (level_valid),
    .alarm_state   (alarm_state),
    .thr_high      (thr_high),
    .thr_low       (thr_low),
    .cfg_err       (cfg_err),
    .state_chg     (state_chg)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (state_chg === 1'b1) chg_cnt++;
    if (cfg_err === 1'b1)   err_cnt++;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [7:0] word);
    sensors_input = word;
    cycles(24);
  endtask

  task automatic press(input logic h, input logic l, input logic [7:0] setup);
    setup_input  = setup;
    saveH_button = h;
    saveL_button = l;
    cycles(2);
    saveH_button = 1'b0;
    saveL_button = 1'b0;
    cycles(3);
  endtask

  initial begin
    reset_n       = 1'b0;
    sensors_input = 8'h01;
    setup_input   = 8'h00;
    saveH_button  = 1'b0;
    saveL_button  = 1'b0;
    cycles(3);
    check("rst_level", 8'(level), 8'd0);
    check("rst_valid", 8'(level_valid), 8'd0);
    check("rst_state", 8'(alarm_state), 8'(S_NORMAL));
    check("rst_thr_high", 8'(thr_high), 8'd8);
    check("rst_thr_low", 8'(thr_low), 8'd0);
    check("rst_cfg_err", 8'(cfg_err), 8'd0);
    reset_n = 1'b1;

    // 1: first accepted word
    chg0 = chg_cnt;
    cycles(24);
    check("s1_level", 8'(level), 8'd1);
    check("s1_valid", 8'(level_valid), 8'd1);
    check("s1_state", 8'(alarm_state), 8'(S_NORMAL));
    check("s1_no_chg", 8'(chg_cnt - chg0), 8'd0);

    // 2: saveL=3 forces LOW with current level
    chg0 = chg_cnt;
    err0 = err_cnt;
    press(1'b0, 1'b1, 8'h07);
    check("s2_thr_low", 8'(thr_low), 8'd3);
    check("s2_state", 8'(alarm_state), 8'(S_LOW));
    check("s2_chg_once", 8'(chg_cnt - chg0), 8'd1);
    check("s2_no_err", 8'(err_cnt - err0), 8'd0);

    // 3: toggling every tick never becomes stable
    for (int i = 0; i < 8; i++) begin
      sensors_input = (i % 2 == 0) ? 8'h03 : 8'h01;
      cycles(4);
    end
    check("s3_toggle_level", 8'(level), 8'd1);
    check("s3_toggle_state", 8'(alarm_state), 8'(S_LOW));
    apply(8'h1F);
    check("s3_level5", 8'(level), 8'd5);
    check("s3_normal", 8'(alarm_state), 8'(S_NORMAL));

    // 4: high threshold and hysteresis
    press(1'b1, 1'b0, 8'h3F);
    check("s4_thr_high", 8'(thr_high), 8'd6);
    check("s4_still_normal", 8'(alarm_state), 8'(S_NORMAL));
    apply(8'h3F);
    check("s4_high", 8'(alarm_state), 8'(S_HIGH));
    apply(8'h1F);
    check("s4_hyst_level", 8'(level), 8'd5);
    check("s4_hyst_high", 8'(alarm_state), 8'(S_HIGH));
    apply(8'h0F);
    check("s4_exit_normal", 8'(alarm_state), 8'(S_NORMAL));

    // 5: gap in thermometer code, then recovery
    apply(8'h11);
    check("s5_fault", 8'(alarm_state), 8'(S_FAULT));
    check("s5_valid0", 8'(level_valid), 8'd0);
    check("s5_level_hold", 8'(level), 8'd4);
    apply(8'hFF);
    check("s5_recover_high", 8'(alarm_state), 8'(S_HIGH));
    check("s5_level8", 8'(level), 8'd8);
    check("s5_valid1", 8'(level_valid), 8'd1);

    // 6: rejected saves
    err0 = err_cnt;
    press(1'b1, 1'b0, 8'h03);
    check("s6a_thr_high", 8'(thr_high), 8'd6);
    check("s6a_err", 8'(err_cnt - err0), 8'd1);
    err0 = err_cnt;
    press(1'b0, 1'b1, 8'h05);
    check("s6b_thr_low", 8'(thr_low), 8'd3);
    check("s6b_err", 8'(err_cnt - err0), 8'd1);
    err0 = err_cnt;
    chg0 = chg_cnt;
    press(1'b1, 1'b1, 8'h0F);
    check("s6c_thr_high", 8'(thr_high), 8'd6);
    check("s6c_thr_low", 8'(thr_low), 8'd3);
    check("s6c_err_single", 8'(err_cnt - err0), 8'd1);
    check("s6c_state_kept", 8'(alarm_state), 8'(S_HIGH));

    // Asynchronous reset in the middle of a cycle
    sensors_input = 8'h01;
    cycles(2);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_level", 8'(level), 8'd0);
    check("ar_valid", 8'(level_valid), 8'd0);
    check("ar_state", 8'(alarm_state), 8'(S_NORMAL));
    check("ar_thr_high", 8'(thr_high), 8'd8);
    check("ar_thr_low", 8'(thr_low), 8'd0);
    check("ar_cfg_err", 8'(cfg_err), 8'd0);
    check("ar_state_chg", 8'(state_chg), 8'd0);
    cycles(2);
    reset_n = 1'b1;
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
